// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the pipeline datapath and the hazard controller.
// Level-sampled every clock edge, with no valid/ready handshake: each input is qualified every cycle and the enables respond combinationally within the same cycle.
interface pipe_hazard_ctrl_if;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        IF_ID_uses_rt;
  logic        ID_EX_MemtoReg;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_rt;
  logic        Jump;
  logic        branch_taken;
  logic        mem_busy;
  logic        cnt_clr;

  logic        pc_write;
  logic        IF_ID_write;
  logic        ID_EX_write;
  logic        EX_MEM_write;
  logic        IF_ID_flush;
  logic        ID_EX_flush;
  logic [1:0]  last_action;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        pend_flush;

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_MemtoReg, ID_EX_RegWrite,
           ID_EX_rt, Jump, branch_taken, mem_busy, cnt_clr,
    input  pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush,
           ID_EX_flush, last_action, stall_cnt, flush_cnt, pend_flush
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, ID_EX_MemtoReg, ID_EX_RegWrite,
           ID_EX_rt, Jump, branch_taken, mem_busy, cnt_clr,
    output pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush,
           ID_EX_flush, last_action, stall_cnt, flush_cnt, pend_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decodes freeze/flush/stall/jump per cycle,
// remembers branches that land during a freeze, and counts stall/flush cycles.
module pipe_hazard_ctrl (
  input logic              clock,
  input logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [2:0] {
    ACT_RUN    = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_FLUSH  = 3'd2,
    ACT_FREEZE = 3'd3,
    ACT_JUMP   = 3'd4
  } action_t;

  action_t     action;
  logic        load_use;
  logic        pend_flush, pend_flush_nxt;
  logic [1:0]  last_action, last_action_nxt;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall_inc, flush_inc;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush;

  assign load_use = hz.ID_EX_MemtoReg && hz.ID_EX_RegWrite && (hz.ID_EX_rt != 5'd0) &&
                    ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                     (hz.IF_ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));

  always_comb begin
    action = ACT_RUN;
    if (hz.mem_busy)                          action = ACT_FREEZE;
    else if (hz.branch_taken || pend_flush)   action = ACT_FLUSH;
    else if (load_use)                        action = ACT_STALL;
    else if (hz.Jump)                         action = ACT_JUMP;
  end

  // Enables are forced low while reset is held, independent of the decode.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (rst_n) begin
      case (action)
        ACT_FREEZE: ;
        ACT_FLUSH: begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        ACT_STALL: begin
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          id_ex_flush  = 1'b1;
        end
        ACT_JUMP: begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
          if_id_flush = 1'b1;
        end
        default: {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b1111;
      endcase
    end
  end

  always_comb begin
    pend_flush_nxt = pend_flush;
    if (action == ACT_FREEZE && hz.branch_taken) pend_flush_nxt = 1'b1;
    else if (action == ACT_FLUSH)                pend_flush_nxt = 1'b0;
    // A jump is reported as RUN in the history register.
    last_action_nxt = (action == ACT_JUMP) ? 2'd0 : action[1:0];
    stall_inc = (action == ACT_STALL) || (action == ACT_FREEZE);
    flush_inc = (action == ACT_FLUSH) || (action == ACT_JUMP);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pend_flush  <= 1'b0;
      last_action <= 2'd0;
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
    end else begin
      pend_flush  <= pend_flush_nxt;
      last_action <= last_action_nxt;
      if (hz.cnt_clr) begin
        stall_cnt <= 16'd0;
        flush_cnt <= 16'd0;
      end else begin
        if (stall_inc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        if (flush_inc && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.IF_ID_write  = if_id_write;
  assign hz.ID_EX_write  = id_ex_write;
  assign hz.EX_MEM_write = ex_mem_write;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.last_action  = last_action;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;
  assign hz.pend_flush   = pend_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clock (clock),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: pending flush, last action code, counters as plain ints.
  int m_pend  = 0;
  int m_last  = 0;
  int m_stall = 0;
  int m_flush = 0;

  // Action -> {pc, IF_ID_w, ID_EX_w, EX_MEM_w, IF_ID_flush, ID_EX_flush}
  // index: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE, 4 JUMP
  localparam logic [5:0] ACT_TAB [5] = '{6'b111100, 6'b001101, 6'b111111,
                                         6'b000000, 6'b111110};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_action();
    bit lu;
    lu = hz.ID_EX_MemtoReg && hz.ID_EX_RegWrite && (hz.ID_EX_rt != 5'd0) &&
         ((hz.ID_EX_rt == hz.IF_ID_rs) || (hz.IF_ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));
    if (hz.mem_busy)                   return 3;
    if (hz.branch_taken || m_pend != 0) return 2;
    if (lu)                            return 1;
    if (hz.Jump)                       return 4;
    return 0;
  endfunction

  always @(posedge clock or negedge rst_n) begin : model_update
    int a;
    if (!rst_n) begin
      m_pend <= 0; m_last <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      a = model_action();
      if (a == 3 && hz.branch_taken) m_pend <= 1;
      else if (a == 2)               m_pend <= 0;
      m_last <= (a == 4) ? 0 : a;
      if (hz.cnt_clr) begin
        m_stall <= 0;
        m_flush <= 0;
      end else begin
        if (a == 1 || a == 3) m_stall <= (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        if (a == 2 || a == 4) m_flush <= (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [5:0] e;
    if (chk_en) begin
      e = rst_n ? ACT_TAB[model_action()] : 6'b000000;
      check("enables", 32'({hz.pc_write, hz.IF_ID_write, hz.ID_EX_write, hz.EX_MEM_write,
                            hz.IF_ID_flush, hz.ID_EX_flush}), 32'(e));
      check("last_action", 32'(hz.last_action), m_last);
      check("stall_cnt", 32'(hz.stall_cnt), m_stall);
      check("flush_cnt", 32'(hz.flush_cnt), m_flush);
    end
  end

  task automatic drive(input int rs, input int rt, input int urt, input int mtr, input int rw,
                       input int exrt, input int jmp, input int br, input int busy, input int clr);
    hz.IF_ID_rs       = 5'(rs);
    hz.IF_ID_rt       = 5'(rt);
    hz.IF_ID_uses_rt  = 1'(urt);
    hz.ID_EX_MemtoReg = 1'(mtr);
    hz.ID_EX_RegWrite = 1'(rw);
    hz.ID_EX_rt       = 5'(exrt);
    hz.Jump           = 1'(jmp);
    hz.branch_taken   = 1'(br);
    hz.mem_busy       = 1'(busy);
    hz.cnt_clr        = 1'(clr);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_pc_write", 32'(hz.pc_write), 0);
    check("rst_stall_cnt", 32'(hz.stall_cnt), 0);
    #2 rst_n = 1'b1;
    adv();

    // First cycle out of reset decodes as RUN.
    idle();
    @(negedge clock);
    check("post_rst_pc_write", 32'(hz.pc_write), 1);
    check("post_rst_IF_ID_flush", 32'(hz.IF_ID_flush), 0);
    adv();

    // Load-use on rs.
    drive(5, 0, 0, 1, 1, 5, 0, 0, 0, 0);
    @(negedge clock);
    check("lu_pc_write", 32'(hz.pc_write), 0);
    check("lu_IF_ID_write", 32'(hz.IF_ID_write), 0);
    check("lu_ID_EX_flush", 32'(hz.ID_EX_flush), 1);
    adv();
    idle();
    @(negedge clock);
    check("lu_last_action", 32'(hz.last_action), 1);
    check("lu_stall_cnt", 32'(hz.stall_cnt), 1);
    adv();

    // Register 0 and unused rt never stall; used rt does.
    drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("r0_pc_write", 32'(hz.pc_write), 1);
    adv();
    drive(1, 7, 0, 1, 1, 7, 0, 0, 0, 0);
    @(negedge clock);
    check("rt_unused_pc_write", 32'(hz.pc_write), 1);
    adv();
    drive(1, 7, 1, 1, 1, 7, 0, 0, 0, 0);
    @(negedge clock);
    check("rt_used_pc_write", 32'(hz.pc_write), 0);
    adv();
    idle();
    @(negedge clock);
    check("rt_stall_cnt", 32'(hz.stall_cnt), 2);
    adv();

    // Deferred branch: 3 freeze cycles, branch in the second.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    check("frz_pc_write", 32'(hz.pc_write), 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    adv();
    idle();
    @(negedge clock);
    check("dfr_IF_ID_flush", 32'(hz.IF_ID_flush), 1);
    check("dfr_ID_EX_flush", 32'(hz.ID_EX_flush), 1);
    adv();
    idle();
    @(negedge clock);
    check("dfr_once_ID_EX_flush", 32'(hz.ID_EX_flush), 0);
    check("dfr_stall_cnt", 32'(hz.stall_cnt), 3);
    check("dfr_flush_cnt", 32'(hz.flush_cnt), 1);
    adv();

    // Branch, load-use and jump together: flush wins.
    drive(5, 0, 0, 1, 1, 5, 1, 1, 0, 0);
    @(negedge clock);
    check("sim_IF_ID_flush", 32'(hz.IF_ID_flush), 1);
    check("sim_pc_write", 32'(hz.pc_write), 1);
    adv();
    idle();
    @(negedge clock);
    check("sim_flush_cnt", 32'(hz.flush_cnt), 2);
    check("sim_stall_cnt", 32'(hz.stall_cnt), 3);
    check("sim_last_action", 32'(hz.last_action), 2);
    adv();

    // Jump alone.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clock);
    check("jmp_IF_ID_flush", 32'(hz.IF_ID_flush), 1);
    check("jmp_ID_EX_flush", 32'(hz.ID_EX_flush), 0);
    adv();
    idle();
    @(negedge clock);
    check("jmp_last_action", 32'(hz.last_action), 0);
    check("jmp_flush_cnt", 32'(hz.flush_cnt), 3);
    adv();

    // Branch during freeze repeated on the first free cycle: one flush.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clock);
    check("rep_ID_EX_flush", 32'(hz.ID_EX_flush), 1);
    adv();
    idle();
    @(negedge clock);
    check("rep_once_ID_EX_flush", 32'(hz.ID_EX_flush), 0);
    check("rep_flush_cnt", 32'(hz.flush_cnt), 4);
    adv();

    // Random traffic over a small register space to provoke matches.
    repeat (3000) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
            ($urandom_range(0, 4) == 0) ? 1 : 0, ($urandom_range(0, 29) == 0) ? 1 : 0);
      adv();
    end

    // Saturation, then clear overriding a same-cycle stall.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (65537) @(posedge clock);
    #1;
    idle();
    @(negedge clock);
    check("sat_stall_cnt", 32'(hz.stall_cnt), 32'hFFFF);
    adv();
    drive(5, 0, 0, 1, 1, 5, 0, 0, 0, 1);
    @(negedge clock);
    check("clr_stall_pc_write", 32'(hz.pc_write), 0);
    adv();
    idle();
    @(negedge clock);
    check("clr_stall_cnt", 32'(hz.stall_cnt), 0);
    check("clr_last_action", 32'(hz.last_action), 1);
    adv();

    // Reset in the middle of a freeze with a pending flush.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock);
    check("mid_pend_set", 32'(hz.pend_flush), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pend", 32'(hz.pend_flush), 0);
    check("mid_rst_last_action", 32'(hz.last_action), 0);
    check("mid_rst_stall_cnt", 32'(hz.stall_cnt), 0);
    check("mid_rst_pc_write", 32'(hz.pc_write), 0);
    idle();
    #2 rst_n = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("mid_rel_pc_write", 32'(hz.pc_write), 1);
    check("mid_rel_IF_ID_flush", 32'(hz.IF_ID_flush), 0);
    check("mid_rel_ID_EX_flush", 32'(hz.ID_EX_flush), 0);
    adv();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: IF_ID_rs  in  5  rs field of the instruction in ID.
REQ-004 SHALL provide: IF_ID_rt  in  5  rt field of the instruction in ID.
REQ-005 SHALL provide: IF_ID_uses_rt  in  1  the ID instruction reads rt as a source.
REQ-006 SHALL provide: ID_EX_MemtoReg  in  1  the EX-stage instruction is a load.
REQ-007 SHALL provide: ID_EX_RegWrite  in  1  the EX-stage instruction writes a register.
REQ-008 SHALL provide: ID_EX_rt  in  5  load destination of the EX-stage instruction.
REQ-009 SHALL provide: Jump  in  1  the ID instruction is a jump.
REQ-010 SHALL provide: branch_taken  in  1  single-cycle pulse, branch resolved taken in EX.
REQ-011 SHALL provide: mem_busy  in  1  data memory not ready; the whole pipe must hold.
REQ-012 SHALL provide: cnt_clr  in  1  synchronous clear of the performance counters.
REQ-013 SHALL provide: pc_write, IF_ID_write, ID_EX_write, EX_MEM_write  out  1 each  stage register load enables.
REQ-014 SHALL provide: IF_ID_flush, ID_EX_flush  out  1 each  zero the stage register contents (bubble).
REQ-015 SHALL provide: last_action  out  2  registered action code of the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
REQ-016 SHALL provide: stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-017 SHALL define load_use = ID_EX_MemtoReg & ID_EX_RegWrite & (ID_EX_rt != 0) & ((ID_EX_rt == IF_ID_rs) | (IF_ID_uses_rt & ID_EX_rt == IF_ID_rt)).
REQ-018 SHALL hold a 1-bit register pend_flush, which records a taken branch that arrives while the pipe is frozen.
REQ-019 SHALL decode the action of each cycle combinationally, with fixed priority FREEZE > FLUSH > STALL > JUMP > RUN.
REQ-020 FREEZE (mem_busy=1): all four write enables 0, both flushes 0; if branch_taken=1, set pend_flush on the next edge.
REQ-021 FLUSH (mem_busy=0 and (branch_taken | pend_flush)): all write enables 1, IF_ID_flush=1, ID_EX_flush=1; clear pend_flush on the next edge.
REQ-022 STALL (load_use, no higher action): pc_write=0, IF_ID_write=0, ID_EX_flush=1, ID_EX_write=1, EX_MEM_write=1.
REQ-023 JUMP (Jump, no higher action): all write enables 1, IF_ID_flush=1, ID_EX_flush=0; last_action SHALL record RUN.
REQ-024 RUN: all write enables 1, both flushes 0.
REQ-025 SHALL register last_action with a latency of exactly one cycle after the decoded action.
REQ-026 stall_cnt SHALL increment on every STALL or FREEZE cycle; flush_cnt SHALL increment on every FLUSH cycle and every JUMP cycle.
REQ-027 Both counters SHALL saturate at 0xFFFF and never wrap.
REQ-028 cnt_clr=1 SHALL set both counters to 0 on the next edge, overriding any increment in that cycle; pend_flush and last_action SHALL be unaffected.
REQ-029 A branch_taken during FREEZE that is repeated in the first non-frozen cycle SHALL cause exactly one FLUSH cycle.
REQ-030 Register index 0 SHALL never cause a load-use STALL.

Reset
REQ-031 While rst_n=0: pend_flush=0, last_action=0, stall_cnt=0, flush_cnt=0, all write enables 0, both flushes 0.
REQ-032 After rst_n is deasserted, the first cycle SHALL decode normally, with no residual flush and no stall.
REQ-033 rst_n asserted mid-FREEZE with pend_flush=1 SHALL discard the pending flush.

Verification
REQ-034 Load-use: ID_EX_MemtoReg=1, ID_EX_RegWrite=1, ID_EX_rt=5, IF_ID_rs=5 for 1 cycle -> pc_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle last_action=1; stall_cnt=1.
REQ-035 Same as REQ-034 but ID_EX_rt=0, or rt match with IF_ID_uses_rt=0 -> RUN, stall_cnt unchanged.
REQ-036 Deferred branch: mem_busy=1 for 3 cycles with branch_taken pulsed in cycle 2 -> 3 FREEZE cycles, then exactly 1 FLUSH cycle with both flushes=1; stall_cnt=3, flush_cnt=1.
REQ-037 Simultaneous events: branch_taken=1, load_use=1 and Jump=1 in one cycle -> FLUSH only; flush_cnt +1, stall_cnt +0.
REQ-038 Saturation/clear: preload with 0xFFFF STALL cycles, apply 2 more -> stall_cnt=0xFFFF; cnt_clr=1 with a STALL in the same cycle -> stall_cnt=0.
REQ-039 Reset mid-operation: set pend_flush via FREEZE+branch, assert rst_n=0 asynchronously -> all registers 0 immediately; after release with mem_busy=0 -> RUN, not FLUSH.
